u2_zm_stream_conv: RTL and testbench
====================================

Name: u2_zm_stream_conv

Overview:
- Pipelined, bidirectional number-format converter between two's complement (U2) and sign-magnitude (ZM), generalised to N bits.
- Per-transaction mode select.
- Valid/ready handshake on both sides, with backpressure.
- Saturating counter of non-representable conversions.
- Sits between the operand-fetch stage and ZM-based arithmetic units; it replaces the single-width combinational converter.

Parameters:
- N, 8, data width in bits (N >= 2).
- CNT_W, 8, width of the error counter.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_valid  in  1  input transaction valid.
- o_ready  out  1  converter can accept an input this cycle.
- i_mode  in  1  0 = U2->ZM, 1 = ZM->U2; sampled with i_data.
- i_data  in  N  operand.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_result  out  N  converted value.
- o_status  out  4  flags: [3] ERR, [2] ZERO, [1] NZERO, [0] NEG.
- i_clr_cnt  in  1  synchronous clear of the error counter.
- o_err_cnt  out  CNT_W  saturating count of accepted results with ERR=1.

Behaviour:
- Reset (async, i_rst=1):
  - Stage-1 valid and stage-2 valid clear; o_valid=0.
  - o_result=0, o_status=4'b0000, o_err_cnt=0.
  - Any in-flight data is dropped; no partial output after release.
- Pipeline: two register stages.
  - S1 captures {i_mode, i_data}.
  - S2 holds the computed {o_result, o_status}.
  - Latency: input accepted on edge k gives o_valid=1 after edge k+1 when unstalled.
- Handshakes:
  - Input accepted when i_valid & o_ready.
  - Output consumed when o_valid & i_ready.
  - s2_load = s1_valid & (!s2_valid | i_ready).
  - o_ready = !s1_valid | s2_load (combinational from i_ready; no other comb paths).
  - Full throughput of 1 transaction/cycle when i_ready held high.
  - o_result/o_status stay stable while o_valid=1 and i_ready=0.
  - Simultaneous accept and consume in a full pipe: both stages advance in the same cycle; no bubble, no loss.
- U2->ZM (i_mode=0):
  - Input MSB=0: result = input; NEG=0.
  - Input MSB=1, input != {1,0...0}: result = {1, magnitude}, magnitude = (~x[N-2:0]) + 1 truncated to N-1 bits; NEG=1.
  - Input = {1,0...0} (most negative, not representable): result saturates to {1, all ones} (-(2^(N-1)-1)); ERR=1, NEG=1, so status = 4'b1001.
- ZM->U2 (i_mode=1):
  - MSB=0: result = input.
  - MSB=1, magnitude != 0: result = (~{0, mag}) + 1; NEG=1.
  - MSB=1, magnitude = 0 (negative zero): result = 0; NZERO=1, ZERO=1, NEG=0; ERR=0.
  - ZM->U2 never sets ERR.
- ZERO is set when o_result represents numeric zero.
- Error counter:
  - Increments on an output handshake with o_status[3]=1.
  - Saturates at 2^CNT_W-1.
  - i_clr_cnt=1 forces 0 next edge; clear wins over a simultaneous increment.
- All arithmetic is computed at N-1 or N bits; no sign extension beyond N.

Decomposition:
- Shared package u2_zm_pkg:
  - Status bit index constants STAT_ERR=3, STAT_ZERO=2, STAT_NZERO=1, STAT_NEG=0.
  - Mode constants MODE_U2_TO_ZM=1'b0, MODE_ZM_TO_U2=1'b1.
  - Typedef for the 4-bit status.
- One combinational sub-module, u2_zm_conv_core: N-parameterised, with inputs mode and data and outputs result and status. Instantiated between S1 and S2. The top holds the handshake, stages and counter.

Test Plan:
- Reset mid-stream: two transactions in flight, pulse i_rst asynchronously between edges -> o_valid drops immediately, o_err_cnt=0; after release, no stale output appears.
- U2->ZM sweep, N=8, i_ready=1: 8'h05 -> 8'h05/4'b0000; 8'hFB -> 8'h85/4'b0001; 8'h00 -> 8'h00/4'b0100; 8'h80 -> 8'hFF/4'b1001. Each result appears 2 cycles after acceptance, back-to-back.
- ZM->U2: 8'h85 -> 8'hFB/4'b0001; 8'h7F -> 8'h7F/4'b0000; 8'h80 -> 8'h00/4'b0110.
- Backpressure: stream 6 inputs with i_ready low for 3 cycles mid-stream:
  - o_ready drops once both stages are full.
  - Held output stays stable.
  - All 6 results arrive in order with none lost or duplicated.
- Error counter, CNT_W=2: five 8'h80 U2->ZM results consumed -> o_err_cnt saturates at 3.
- Counter clear: assert i_clr_cnt on the same cycle as an ERR handshake -> o_err_cnt=0.
- Parameter N=16: 16'h8000 -> 16'hFFFF/4'b1001; 16'hFFFF (U2->ZM) -> 16'h8001/4'b0001.

Source files
------------

// File: rtl/u2_zm_pkg.sv
// Shared definitions for the U2 <-> ZM stream converter: status bit layout,
// mode encoding and a small status helper.
package u2_zm_pkg;

   typedef logic [3:0] status_t;

   localparam int STAT_ERR   = 3;
   localparam int STAT_ZERO  = 2;
   localparam int STAT_NZERO = 1;
   localparam int STAT_NEG   = 0;

   localparam logic MODE_U2_TO_ZM = 1'b0;
   localparam logic MODE_ZM_TO_U2 = 1'b1;

   function automatic logic is_err(input status_t st);
      return st[STAT_ERR];
   endfunction

endpackage

// File: rtl/u2_zm_conv_core.sv
// Combinational N-bit converter between two's complement and sign-magnitude,
// producing the converted value and its status flags.
module u2_zm_conv_core
   import u2_zm_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         mode,
   input  logic [N-1:0] data,
   output logic [N-1:0] result,
   output status_t      status
);

   logic         sign_s;
   logic [N-2:0] low_s;
   logic [N-2:0] neg_low_s;
   logic         low_zero_s;

   assign sign_s     = data[N-1];
   assign low_s      = data[N-2:0];
   assign neg_low_s  = ~low_s + (N-1)'(1'b1);
   assign low_zero_s = (low_s == {(N-1){1'b0}});

   // Conversion and flag generation for both directions.
   always_comb begin
      result = data;
      status = 4'b0000;
      case (mode)
         MODE_U2_TO_ZM: begin
            if (sign_s) begin
               status[STAT_NEG] = 1'b1;
               if (low_zero_s) begin
                  // Most negative U2 value has no ZM encoding: saturate.
                  result           = {1'b1, {(N-1){1'b1}}};
                  status[STAT_ERR] = 1'b1;
               end else begin
                  result = {1'b1, neg_low_s};
               end
            end else begin
               result = data;
            end
         end
         MODE_ZM_TO_U2: begin
            if (sign_s) begin
               if (low_zero_s) begin
                  result             = {N{1'b0}};
                  status[STAT_NZERO] = 1'b1;
               end else begin
                  result           = ~{1'b0, low_s} + N'(1'b1);
                  status[STAT_NEG] = 1'b1;
               end
            end else begin
               result = data;
            end
         end
         default: begin
            result = data;
         end
      endcase
      status[STAT_ZERO] = (result == {N{1'b0}});
   end

endmodule

// File: rtl/u2_zm_stream_conv.sv
// Two-stage valid/ready pipeline around the U2/ZM conversion core, with a
// saturating counter of consumed results flagged as non-representable.
module u2_zm_stream_conv
   import u2_zm_pkg::*;
#(
   parameter int N     = 8,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic             i_mode,
   input  logic [N-1:0]     i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [N-1:0]     o_result,
   output logic [3:0]       o_status,
   input  logic             i_clr_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             s1_valid_r;
   logic             s1_mode_r;
   logic [N-1:0]     s1_data_r;
   logic             s2_valid_r;
   logic [N-1:0]     result_r;
   status_t          status_r;
   logic [CNT_W-1:0] cnt_r;

   logic             s2_load_s;
   logic             accept_s;
   logic             consume_s;
   logic [N-1:0]     core_result_s;
   status_t          core_status_s;

   assign s2_load_s = s1_valid_r & (~s2_valid_r | i_ready);
   assign o_ready   = ~s1_valid_r | s2_load_s;
   assign accept_s  = i_valid & o_ready;
   assign consume_s = s2_valid_r & i_ready;

   u2_zm_conv_core #(.N(N)) u_core (
      .mode   (s1_mode_r),
      .data   (s1_data_r),
      .result (core_result_s),
      .status (core_status_s)
   );

   // Stage 1: capture the accepted operand and its mode.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s1_valid_r <= 1'b0;
         s1_mode_r  <= 1'b0;
         s1_data_r  <= {N{1'b0}};
      end else if (accept_s) begin
         s1_valid_r <= 1'b1;
         s1_mode_r  <= i_mode;
         s1_data_r  <= i_data;
      end else if (s2_load_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage 2: hold the converted result until downstream takes it.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         s2_valid_r <= 1'b0;
         result_r   <= {N{1'b0}};
         status_r   <= 4'b0000;
      end else if (s2_load_s) begin
         s2_valid_r <= 1'b1;
         result_r   <= core_result_s;
         status_r   <= core_status_s;
      end else if (consume_s) begin
         s2_valid_r <= 1'b0;
      end
   end

   // Saturating error counter; a clear beats a coincident increment.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (i_clr_cnt) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (consume_s && is_err(status_r) && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_W'(1'b1);
      end
   end

   assign o_valid   = s2_valid_r;
   assign o_result  = result_r;
   assign o_status  = status_r;
   assign o_err_cnt = cnt_r;

endmodule

// File: tb/tb_u2_zm_stream_conv.sv
// Self-checking bench: an 8-bit/2-bit-counter instance and a 16-bit instance
// checked against an arithmetic reference model and a capacity-2 queue model.
module tb_u2_zm_stream_conv;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_vld, a_mode, a_rdy, a_clr, a_oready, a_ovalid;
   logic [7:0]  a_data, a_res;
   logic [3:0]  a_st;
   logic [1:0]  a_cnt;

   logic        b_vld, b_mode, b_rdy, b_clr, b_oready, b_ovalid;
   logic [15:0] b_data, b_res;
   logic [3:0]  b_st;
   logic [7:0]  b_cnt;

   u2_zm_stream_conv #(.N(8), .CNT_W(2)) dut_a (
      .i_clk(clk), .i_rst(rst), .i_valid(a_vld), .o_ready(a_oready),
      .i_mode(a_mode), .i_data(a_data), .o_valid(a_ovalid), .i_ready(a_rdy),
      .o_result(a_res), .o_status(a_st), .i_clr_cnt(a_clr), .o_err_cnt(a_cnt)
   );

   u2_zm_stream_conv #(.N(16), .CNT_W(8)) dut_b (
      .i_clk(clk), .i_rst(rst), .i_valid(b_vld), .o_ready(b_oready),
      .i_mode(b_mode), .i_data(b_data), .o_valid(b_ovalid), .i_ready(b_rdy),
      .o_result(b_res), .o_status(b_st), .i_clr_cnt(b_clr), .o_err_cnt(b_cnt)
   );

   typedef struct {
      longint     res;
      logic [3:0] st;
      int         acc;
   } exp_t;

   exp_t   qa[$];
   exp_t   qb[$];
   int     cnt_a, cnt_b;
   int     cyc;
   int     checks;
   int     failures;
   logic   a_accepted;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference conversion computed on plain integers.
   function automatic void ref_conv(input int n, input logic m, input longint x,
                                    output longint r, output logic [3:0] st);
      longint half, full, mag;
      half = longint'(1) << (n - 1);
      full = longint'(1) << n;
      st   = 4'b0000;
      if (x < half) begin
         r = x;
      end else if (m == 1'b0) begin
         st[0] = 1'b1;
         if (x == half) begin
            r     = full - 1;
            st[3] = 1'b1;
         end else begin
            r = half + (full - x);
         end
      end else begin
         mag = x - half;
         if (mag == 0) begin
            r     = 0;
            st[1] = 1'b1;
         end else begin
            r     = full - mag;
            st[0] = 1'b1;
         end
      end
      st[2] = (r == 0);
   endfunction

   // One clock: check outputs against the model, update the model, advance.
   task automatic tick();
      exp_t   e;
      logic   pop, push, err;
      #1;
      chk("a_ready", 64'(a_oready), 64'((qa.size() < 2) || a_rdy));
      if (qa.size() > 0 && (cyc - qa[0].acc) >= 2) begin
         chk("a_valid", 64'(a_ovalid), 64'd1);
         chk("a_result", 64'(a_res), 64'(qa[0].res));
         chk("a_status", 64'(a_st), 64'(qa[0].st));
      end else begin
         chk("a_valid", 64'(a_ovalid), 64'd0);
      end
      chk("a_cnt", 64'(a_cnt), 64'(cnt_a));
      pop  = (qa.size() > 0) && ((cyc - qa[0].acc) >= 2) && a_rdy;
      push = a_vld && ((qa.size() < 2) || a_rdy);
      err  = pop && qa[0].st[3];
      if (a_clr) cnt_a = 0;
      else if (err && cnt_a < 3) cnt_a++;
      if (pop) void'(qa.pop_front());
      if (push) begin
         ref_conv(8, a_mode, longint'(a_data), e.res, e.st);
         e.acc = cyc;
         qa.push_back(e);
      end
      a_accepted = push;

      chk("b_ready", 64'(b_oready), 64'((qb.size() < 2) || b_rdy));
      if (qb.size() > 0 && (cyc - qb[0].acc) >= 2) begin
         chk("b_valid", 64'(b_ovalid), 64'd1);
         chk("b_result", 64'(b_res), 64'(qb[0].res));
         chk("b_status", 64'(b_st), 64'(qb[0].st));
      end else begin
         chk("b_valid", 64'(b_ovalid), 64'd0);
      end
      chk("b_cnt", 64'(b_cnt), 64'(cnt_b));
      pop  = (qb.size() > 0) && ((cyc - qb[0].acc) >= 2) && b_rdy;
      push = b_vld && ((qb.size() < 2) || b_rdy);
      err  = pop && qb[0].st[3];
      if (b_clr) cnt_b = 0;
      else if (err && cnt_b < 255) cnt_b++;
      if (pop) void'(qb.pop_front());
      if (push) begin
         ref_conv(16, b_mode, longint'(b_data), e.res, e.st);
         e.acc = cyc;
         qb.push_back(e);
      end

      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic send_a(input logic m, input logic [7:0] d);
      a_vld = 1'b1; a_mode = m; a_data = d;
      tick();
      a_vld = 1'b0;
   endtask

   task automatic drain();
      a_vld = 1'b0; b_vld = 1'b0; a_rdy = 1'b1; b_rdy = 1'b1;
      for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) tick();
      chk("drain_a", 64'(qa.size()), 64'd0);
      chk("drain_b", 64'(qb.size()), 64'd0);
   endtask

   logic [7:0] bp_vals [6];
   int         sent;

   initial begin
      checks = 0; failures = 0; cyc = 0; cnt_a = 0; cnt_b = 0;
      a_vld = 1'b0; a_mode = 1'b0; a_data = 8'h00; a_rdy = 1'b1; a_clr = 1'b0;
      b_vld = 1'b0; b_mode = 1'b0; b_data = 16'h0000; b_rdy = 1'b1; b_clr = 1'b0;
      a_accepted = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_a_valid", 64'(a_ovalid), 64'd0);
      chk("rst_a_result", 64'(a_res), 64'd0);
      chk("rst_a_status", 64'(a_st), 64'd0);
      chk("rst_a_cnt", 64'(a_cnt), 64'd0);
      chk("rst_b_valid", 64'(b_ovalid), 64'd0);
      rst = 1'b0;

      // Directed U2->ZM then ZM->U2 sweep on A, 16-bit corner cases on B.
      a_vld = 1'b1; b_vld = 1'b1;
      a_mode = 1'b0; a_data = 8'h05; b_mode = 1'b0; b_data = 16'h8000; tick();
      a_data = 8'hFB; b_data = 16'hFFFF; tick();
      b_vld = 1'b0;
      a_data = 8'h00; tick();
      a_data = 8'h80; tick();
      a_mode = 1'b1; a_data = 8'h85; tick();
      a_data = 8'h7F; tick();
      a_data = 8'h80; tick();
      drain();

      // Backpressure: six inputs, downstream stalled for three cycles.
      for (int i = 0; i < 6; i++) bp_vals[i] = 8'($urandom);
      sent = 0; a_mode = 1'b0;
      for (int t = 0; t < 20; t++) begin
         a_rdy = !(t >= 2 && t < 5);
         a_vld = (sent < 6);
         a_data = (sent < 6) ? bp_vals[sent] : 8'h00;
         tick();
         if (a_accepted) sent++;
      end
      chk("bp_sent", 64'(sent), 64'd6);
      drain();

      // Random traffic on both instances.
      for (int t = 0; t < 300; t++) begin
         a_vld = 1'($urandom); a_mode = 1'($urandom); a_rdy = ($urandom_range(0, 3) != 0);
         a_data = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
         a_clr = ($urandom_range(0, 15) == 0);
         b_vld = 1'($urandom); b_mode = 1'($urandom); b_rdy = ($urandom_range(0, 3) != 0);
         b_data = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
         b_clr = ($urandom_range(0, 31) == 0);
         tick();
      end
      a_clr = 1'b0; b_clr = 1'b0;
      drain();

      // Counter saturation at 3 with a 2-bit counter.
      a_clr = 1'b1; tick(); a_clr = 1'b0;
      for (int i = 0; i < 5; i++) send_a(1'b0, 8'h80);
      drain();
      chk("cnt_sat", 64'(a_cnt), 64'd3);

      // Asynchronous reset with two transactions in flight.
      a_vld = 1'b1; a_mode = 1'b0; a_data = 8'h80; tick();
      a_data = 8'hFB; tick();
      a_vld = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_a_valid", 64'(a_ovalid), 64'd0);
      chk("arst_a_cnt", 64'(a_cnt), 64'd0);
      chk("arst_a_ready", 64'(a_oready), 64'd1);
      #1 rst = 1'b0;
      qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
      repeat (4) tick();

      // Clear coincident with an ERR handshake.
      send_a(1'b0, 8'h80);
      drain();
      chk("cnt_one", 64'(a_cnt), 64'd1);
      send_a(1'b0, 8'h80);
      tick();
      a_clr = 1'b1; tick(); a_clr = 1'b0;
      tick();
      chk("cnt_clr_win", 64'(a_cnt), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
